macu_array_seq: RTL and testbench
=================================

Name: macu_array_seq

Overview:
- Sequencer for a ROWS x COLS weight-stationary array of signed MAC cells.
- Activations flow horizontally through the array; partial sums flow down the rows.
- Per job: loads one weight row per accepted beat through the cells' weight-enable inputs, streams a configured number of activation vectors, then drains the pipeline.
- Tracks when each column's bottom-row result is valid. The array has no stall input, so all timing is tracked here.

Parameters:
- ROWS, 4, array rows; one weight-load beat per row.
- COLS, 4, array columns; column c result lags column 0 by c cycles.
- CNT_W, 16, width of vector count.
- LAT, ROWS+2, cycles from activation-accept cycle to column-0 result-valid cycle.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-high reset. Port name is fixed by convention; asserted = 1.
- start  in  1  job start pulse; sampled only in IDLE.
- vec_num  in  CNT_W  activation vectors per job; latched on accepted start.
- busy  out  1  high from the cycle after an accepted start through the DONE cycle.
- done  out  1  one-cycle pulse at job end.
- w_valid  in  1  weight row beat available.
- w_ready  out  1  high in LOAD_W.
- w_row_en  out  ROWS  one-hot weight enable to array row; combinational from w_valid and w_ready.
- x_valid  in  1  activation vector available.
- x_ready  out  1  high in STREAM while issued < vec_num.
- x_en  out  1  x_valid and x_ready. When low, the array wrapper drives xi = 0 (bubble).
- out_col_valid  out  COLS  bit c high when column c bottom output holds a valid result.
- out_last  out  1  high with out_col_valid[COLS-1] for the final vector.

Behaviour:
- Reset:
  - Synchronous, active-high; has priority over everything, including start.
  - Next cycle: state IDLE, counters 0, delay line cleared, all outputs 0.
  - Reset during any state aborts the job; no stale out_col_valid afterwards.
- States: IDLE, LOAD_W, STREAM, DRAIN, DONE.
- IDLE:
  - start=1 latches vec_num.
  - vec_num != 0 -> LOAD_W.
  - vec_num == 0 -> DONE. No weight beats, no x_ready.
- LOAD_W:
  - w_ready=1.
  - Each w_valid beat asserts w_row_en = 1<<row that cycle, then row++.
  - The beat at row ROWS-1 -> STREAM, row cleared.
  - w_row_en is 0 at all other times, so weights are held.
- STREAM:
  - Each x_en increments issued.
  - The cycle where issued reaches vec_num -> DRAIN.
  - Bubbles (x_valid=0) are allowed and propagate as invalid slots.
- Delay line:
  - Shift register of length LAT+COLS-1 carrying {valid, last}; last = accept of vector vec_num-1.
  - out_col_valid[c] = tap LAT-1+c.
  - out_last = last bit at tap LAT+COLS-2, gated by valid.
  - The delay line shifts every cycle in every state; it never stalls.
- DRAIN: wait for out_last, then -> DONE.
- DONE: done=1 for one cycle, then -> IDLE. start is ignored in DONE.
- Ignored inputs:
  - start while busy is ignored.
  - vec_num changes after latch have no effect.
- Counter width: issued is CNT_W bits; the max vec_num is 2^CNT_W-1 with no wrap.
- Back-to-back jobs: a new start is accepted in the IDLE cycle after DONE.
- Weights are reloaded every job.

Decomposition:
- Package macu_seq_pkg holds:
  - state enum (IDLE/LOAD_W/STREAM/DRAIN/DONE);
  - constant default-latency function (ROWS+2);
  - one-hot helper function.
- Sub-module macu_vld_pipe: parameterised {valid, last} shift register with COLS taps. It is the delay line described above.

Test Plan:
(ROWS=4, COLS=4, LAT=6, start high in cycle 0, weights and activations back-to-back unless stated)
- Reset held 3 cycles with w_valid/x_valid=1 -> all outputs 0, w_ready=0, x_ready=0.
- vec_num=3 -> busy from cycle 1; w_row_en 0001/0010/0100/1000 in cycles 1-4; x_en cycles 5-7; out_col_valid[0] cycles 11-13; out_col_valid[3] cycles 14-16; out_last cycle 16 only; done cycle 17; busy low cycle 18.
- Gaps:
  - w_valid low in cycle 2 -> row 1 enable in cycle 3.
  - x_valid pattern 1,0,0,1,1 -> out_col_valid[0] reproduces the pattern exactly LAT cycles later.
  - Exactly vec_num col-0 valids.
- vec_num=0 -> done cycle 1; w_row_en, x_ready, out_col_valid never asserted.
- Reset in STREAM after 2 accepts -> next cycle all outputs 0; no out_col_valid for 20 cycles; a fresh job with vec_num=1 then completes normally.
- start re-pulsed in cycles 5 and 17 with vec_num=9 -> ignored; job runs with the original count 3.

Source files
------------

// File: rtl/macu_seq_pkg.sv
// rtl/macu_seq_pkg.sv - shared types and helpers for the MAC array sequencer
package macu_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_e;

  // Activation accept to column-0 result: skew-in, ROWS MAC stages, output register.
  function automatic int default_lat(input int rows);
    return rows + 2;
  endfunction

  function automatic logic [31:0] onehot(input int unsigned idx);
    return 32'd1 << idx;
  endfunction

endpackage

// File: rtl/macu_vld_pipe.sv
// rtl/macu_vld_pipe.sv - {valid, last} delay line with one tap per array column
module macu_vld_pipe #(
  parameter int LAT  = 6,
  parameter int COLS = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic            in_last,
  output logic [COLS-1:0] out_col_valid,
  output logic            out_last
);

  localparam int DEPTH = LAT + COLS - 1;

  logic [DEPTH-1:0] vld_q, vld_d;
  logic [DEPTH-1:0] last_q, last_d;

  // Free-running shift; bubbles enter as invalid slots and the line never stalls.
  always_comb begin
    vld_d     = '0;
    last_d    = '0;
    vld_d[0]  = in_valid;
    last_d[0] = in_valid & in_last;
    for (int i = 1; i < DEPTH; i++) begin
      vld_d[i]  = vld_q[i-1];
      last_d[i] = last_q[i-1];
    end
  end

  // Delay-line registers; reset flushes every slot so no stale results survive an abort.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= '0;
      last_q <= '0;
    end else begin
      vld_q  <= vld_d;
      last_q <= last_d;
    end
  end

  // Column c result lags column 0 by c cycles; last is reported at the final column.
  always_comb begin
    out_col_valid = '0;
    for (int c = 0; c < COLS; c++) begin
      out_col_valid[c] = vld_q[LAT-1+c];
    end
    out_last = vld_q[DEPTH-1] & last_q[DEPTH-1];
  end

endmodule

// File: rtl/macu_array_seq.sv
// rtl/macu_array_seq.sv - weight-load / stream / drain sequencer for a weight-stationary MAC array
module macu_array_seq
  import macu_seq_pkg::*;
#(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int CNT_W = 16,
  parameter int LAT   = default_lat(ROWS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] vec_num,
  output logic             busy,
  output logic             done,
  input  logic             w_valid,
  output logic             w_ready,
  output logic [ROWS-1:0]  w_row_en,
  input  logic             x_valid,
  output logic             x_ready,
  output logic             x_en,
  output logic [COLS-1:0]  out_col_valid,
  output logic             out_last
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] vec_q, vec_d;
  logic [CNT_W-1:0] issued_q, issued_d;
  logic [RW-1:0]    row_q, row_d;
  logic             x_last;

  // Next-state, counters and handshake outputs.
  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    issued_d = issued_q;
    row_d    = row_q;

    busy     = (state_q != S_IDLE);
    done     = (state_q == S_DONE);
    w_ready  = (state_q == S_LOAD_W);
    x_ready  = (state_q == S_STREAM) && (issued_q != vec_q);
    x_en     = x_valid & x_ready;
    x_last   = x_en && (issued_q == vec_q - CNT_W'(1));
    w_row_en = (w_valid && w_ready) ? ROWS'(onehot(row_q)) : '0;

    case (state_q)
      S_IDLE: begin
        issued_d = '0;
        row_d    = '0;
        if (start) begin
          vec_d   = vec_num;
          state_d = (vec_num != '0) ? S_LOAD_W : S_DONE;
        end
      end
      S_LOAD_W: begin
        if (w_valid) begin
          if (row_q == RW'(ROWS - 1)) begin
            row_d   = '0;
            state_d = S_STREAM;
          end else begin
            row_d = row_q + RW'(1);
          end
        end
      end
      S_STREAM: begin
        if (x_en) begin
          issued_d = issued_q + CNT_W'(1);
          if (issued_d == vec_q) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (out_last) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer state registers with synchronous reset taking priority over start.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q  <= S_IDLE;
      vec_q    <= '0;
      issued_q <= '0;
      row_q    <= '0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      issued_q <= issued_d;
      row_q    <= row_d;
    end
  end

  macu_vld_pipe #(
    .LAT  (LAT),
    .COLS (COLS)
  ) u_vld_pipe (
    .clk           (clk),
    .rst           (rst_n),
    .in_valid      (x_en),
    .in_last       (x_last),
    .out_col_valid (out_col_valid),
    .out_last      (out_last)
  );

endmodule

// File: tb/tb_macu_array_seq.sv
// tb/tb_macu_array_seq.sv - directed self-checking bench for macu_array_seq
module tb_macu_array_seq;

  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int CNT_W = 16;
  localparam logic [63:0] ALL = '1;

  logic             clk = 1'b1;
  logic             rst_n = 1'b1;
  logic             start = 1'b0;
  logic [CNT_W-1:0] vec_num = '0;
  logic             busy, done;
  logic             w_valid = 1'b0;
  logic             w_ready;
  logic [ROWS-1:0]  w_row_en;
  logic             x_valid = 1'b0;
  logic             x_ready, x_en;
  logic [COLS-1:0]  out_col_valid;
  logic             out_last;

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] busy_l, done_l, wrdy_l, xrdy_l, xen_l, last_l;
  logic [63:0] wen_l [ROWS];
  logic [63:0] ocv_l [COLS];

  macu_array_seq #(
    .ROWS  (ROWS),
    .COLS  (COLS),
    .CNT_W (CNT_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .vec_num       (vec_num),
    .busy          (busy),
    .done          (done),
    .w_valid       (w_valid),
    .w_ready       (w_ready),
    .w_row_en      (w_row_en),
    .x_valid       (x_valid),
    .x_ready       (x_ready),
    .x_en          (x_en),
    .out_col_valid (out_col_valid),
    .out_last      (out_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rng(input int lo, input int hi);
    logic [63:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  // Cycle 0 of a run is the cycle whose inputs are applied first; bit k of each log is cycle k.
  task automatic run(input int n, input logic [63:0] st, input logic [63:0] wv,
                     input logic [63:0] xv, input logic [63:0] rs,
                     input logic [CNT_W-1:0] v0, input logic [CNT_W-1:0] vn);
    busy_l = '0; done_l = '0; wrdy_l = '0; xrdy_l = '0; xen_l = '0; last_l = '0;
    for (int r = 0; r < ROWS; r++) wen_l[r] = '0;
    for (int c = 0; c < COLS; c++) ocv_l[c] = '0;
    for (int cyc = 0; cyc < n; cyc++) begin
      rst_n   = rs[cyc];
      start   = st[cyc];
      w_valid = wv[cyc];
      x_valid = xv[cyc];
      vec_num = (cyc == 0) ? v0 : vn;
      @(negedge clk);
      busy_l[cyc] = busy;
      done_l[cyc] = done;
      wrdy_l[cyc] = w_ready;
      xrdy_l[cyc] = x_ready;
      xen_l[cyc]  = x_en;
      last_l[cyc] = out_last;
      for (int r = 0; r < ROWS; r++) wen_l[r][cyc] = w_row_en[r];
      for (int c = 0; c < COLS; c++) ocv_l[c][cyc] = out_col_valid[c];
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    rst_n = 1'b0;
  endtask

  task automatic check_quiet(input string tag, input logic [63:0] m);
    logic [63:0] any;
    any = busy_l | done_l | wrdy_l | xrdy_l | xen_l | last_l;
    for (int r = 0; r < ROWS; r++) any = any | wen_l[r];
    for (int c = 0; c < COLS; c++) any = any | ocv_l[c];
    chk(tag, any & m, '0);
  endtask

  // Expected waveform of the basic vec_num=3 job with back-to-back beats.
  task automatic check_basic(input string tag);
    logic [63:0] m;
    m = rng(0, 24);
    chk({tag, "_busy"}, busy_l & m, rng(1, 17));
    chk({tag, "_done"}, done_l & m, rng(17, 17));
    chk({tag, "_w_ready"}, wrdy_l & m, rng(1, 4));
    chk({tag, "_x_ready"}, xrdy_l & m, rng(5, 7));
    chk({tag, "_x_en"}, xen_l & m, rng(5, 7));
    chk({tag, "_last"}, last_l & m, rng(16, 16));
    for (int r = 0; r < ROWS; r++) chk($sformatf("%s_wen%0d", tag, r), wen_l[r] & m, rng(1 + r, 1 + r));
    for (int c = 0; c < COLS; c++) chk($sformatf("%s_ocv%0d", tag, c), ocv_l[c] & m, rng(11 + c, 13 + c));
  endtask

  initial begin
    // Reset held three cycles with valids high.
    run(4, '0, ALL, ALL, rng(0, 2), '0, '0);
    check_quiet("reset_outputs", rng(1, 3));

    // Basic job, vec_num = 3.
    run(25, 64'd1, ALL, ALL, '0, 16'd3, 16'd3);
    check_basic("basic");

    // Weight gap in cycle 2, activation pattern 1,0,0,1,1 from cycle 6.
    run(25, 64'd1, ~(64'd1 << 2), ~((64'd1 << 7) | (64'd1 << 8)), '0, 16'd3, 16'd3);
    chk("gap_wen0", wen_l[0], rng(1, 1));
    chk("gap_wen1", wen_l[1], rng(3, 3));
    chk("gap_wen2", wen_l[2], rng(4, 4));
    chk("gap_wen3", wen_l[3], rng(5, 5));
    chk("gap_x_en", xen_l, (64'd1 << 6) | (64'd1 << 9) | (64'd1 << 10));
    chk("gap_ocv0", ocv_l[0], (64'd1 << 12) | (64'd1 << 15) | (64'd1 << 16));
    chk("gap_ocv3", ocv_l[3], (64'd1 << 15) | (64'd1 << 18) | (64'd1 << 19));
    chk("gap_ocv0_count", 64'($countones(ocv_l[0])), 64'd3);
    chk("gap_last", last_l, rng(19, 19));
    chk("gap_done", done_l, rng(20, 20));
    chk("gap_busy", busy_l, rng(1, 20));

    // Zero-length job goes straight to DONE.
    run(10, 64'd1, ALL, ALL, '0, 16'd0, 16'd0);
    chk("zero_done", done_l, rng(1, 1));
    chk("zero_busy", busy_l, rng(1, 1));
    check_quiet("zero_quiet", rng(2, 9));
    chk("zero_no_xrdy", xrdy_l | wrdy_l, '0);

    // Reset during STREAM after two accepts, then a fresh single-vector job.
    run(28, 64'd1, ALL, ALL, rng(7, 7), 16'd3, 16'd3);
    chk("abort_x_en", xen_l & rng(0, 6), rng(5, 6));
    check_quiet("abort_quiet", rng(8, 27));
    run(20, 64'd1, ALL, ALL, '0, 16'd1, 16'd1);
    chk("fresh_x_en", xen_l, rng(5, 5));
    chk("fresh_ocv0", ocv_l[0], rng(11, 11));
    chk("fresh_ocv3", ocv_l[3], rng(14, 14));
    chk("fresh_last", last_l, rng(14, 14));
    chk("fresh_done", done_l, rng(15, 15));
    chk("fresh_busy", busy_l, rng(1, 15));

    // start re-pulsed while busy and in DONE with a different count is ignored.
    run(25, (64'd1) | (64'd1 << 5) | (64'd1 << 17), ALL, ALL, '0, 16'd3, 16'd9);
    check_basic("repulse");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
